// File: rtl/multi_field_extract_pkg.sv
// -----------------------------------------------------------------------------
// multi_field_extract_pkg : shared types and constants for the L3 field extractor
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package multi_field_extract_pkg;

  localparam int W = 32;
  localparam int B = 8;

  localparam logic [15:0] ETH_IPV4  = 16'h0800;
  localparam logic [15:0] ETH_IPV6  = 16'h86DD;
  localparam logic [15:0] ETH_VLAN  = 16'h8100;
  localparam logic [15:0] ETH_QINQ  = 16'h88A8;
  localparam logic [15:0] ETH_VLAN2 = 16'h9100;

  typedef struct packed {
    logic [W-1:0] data;
    logic         valid;
    logic         sop;
    logic         eop;
  } avln_st_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ETH  = 2'd1,
    S_L3   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] word;
    logic [7:0] offset;
    logic [7:0] size;
  } field_desc_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_field_extract_field_slot.sv
// -----------------------------------------------------------------------------
// field_slot : captures one L3 field, latching the upper part of a straddling one
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module field_slot
  import multi_field_extract_pkg::*;
#(
  parameter int          MAX_FIELD_SIZE = 32,
  parameter field_desc_t DESC           = {8'd0, 8'd0, 8'd8}
) (
  input  logic                      sys_clk,
  input  logic                      reset_n,
  input  avln_st_t                  i_st,
  input  logic                      i_en,
  input  logic                      i_clr,
  input  logic [7:0]                i_l3_idx,
  output logic [MAX_FIELD_SIZE-1:0] o_field,
  output logic                      o_valid,
  output logic                      o_done
);

  localparam int c_off  = int'(DESC.offset);
  localparam int c_size = int'(DESC.size);

  logic                      r_done;
  logic                      r_valid;
  logic [MAX_FIELD_SIZE-1:0] r_field;
  logic                      w_hit_lo;
  logic                      w_hit_hi;
  logic                      w_cap;
  logic [MAX_FIELD_SIZE-1:0] w_val;
  logic                      w_unused;

  assign w_hit_lo = i_en & (i_l3_idx == DESC.word);
  assign w_hit_hi = i_en & ({1'b0, i_l3_idx} == ({1'b0, DESC.word} + 9'd1));
  assign w_unused = ^i_st;

  generate
    if (c_off + c_size > W) begin : g_straddle
      localparam int c_hi = W - c_off;
      localparam int c_lo = c_off + c_size - W;
      logic [c_hi-1:0] r_hi;

      // Low bits of the first word are the field's MSBs; held across idle cycles.
      always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
          r_hi <= '0;
        end else if (w_hit_lo && !r_done) begin
          r_hi <= i_st.data[c_hi-1:0];
        end
      end

      assign w_cap = w_hit_hi & ~r_done;
      assign w_val = MAX_FIELD_SIZE'({r_hi, i_st.data[W-1 -: c_lo]});
    end else begin : g_single
      assign w_cap = w_hit_lo & ~r_done;
      assign w_val = MAX_FIELD_SIZE'(i_st.data[W-1-c_off -: c_size]);
    end
  endgenerate

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_field <= '0;
    end else begin
      r_valid <= w_cap;
      if (i_clr) begin
        r_done <= 1'b0;
      end else if (w_cap) begin
        r_done  <= 1'b1;
        r_field <= w_val;
      end
    end
  end

  assign o_field = r_field;
  assign o_valid = r_valid;
  assign o_done  = r_done | w_cap;

endmodule

`default_nettype wire

// File: rtl/multi_field_extract.sv
// -----------------------------------------------------------------------------
// multi_field_extract : Ethernet/VLAN parser that captures N_FIELDS L3 fields
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module multi_field_extract
  import multi_field_extract_pkg::*;
#(
  parameter int                    N_FIELDS       = 2,
  parameter int                    MAX_FIELD_SIZE = 32,
  parameter logic [N_FIELDS*8-1:0] FIELD_WORD     = {8'd1, 8'd2},
  parameter logic [N_FIELDS*8-1:0] FIELD_OFFSET   = {8'd0, 8'd16},
  parameter logic [N_FIELDS*8-1:0] FIELD_SIZE     = {8'd16, 8'd8},
  parameter int                    ETYPE_WORD     = 3,
  parameter int                    MAX_VLAN_TAGS  = 2,
  parameter bit                    IPV6_EN        = 1'b0
) (
  input  logic                                     sys_clk,
  input  logic                                     reset_n,
  input  avln_st_t                                 in,
  output logic                                     l3_start,
  output logic                                     is_ipv6,
  output logic [N_FIELDS-1:0][MAX_FIELD_SIZE-1:0]  field,
  output logic [N_FIELDS-1:0]                      field_valid,
  output logic                                     all_valid,
  output logic                                     abort
);

  state_t        r_state;
  logic [7:0]    r_wcnt;
  logic [1:0]    r_tags;
  logic [7:0]    r_l3idx;
  logic          r_l3_start;
  logic          r_is_ipv6;
  logic          r_all_valid;
  logic          r_abort;

  logic [7:0]    w_widx;
  logic [1:0]    w_tags;
  logic [15:0]   w_ety;
  logic          w_eth_ctx;
  logic          w_eth_hit;
  logic          w_tag_ok;
  logic          w_v4;
  logic          w_v6;
  logic          w_l3_ok;
  logic          w_to_done;
  logic          w_l3_acc;
  logic          w_clr;
  logic          w_all_done;
  logic          w_outst;
  logic [N_FIELDS-1:0] w_done;

  // A sop word is always index 0 and always starts a fresh tag count.
  assign w_widx    = in.sop ? 8'd0 : sat_inc(r_wcnt);
  assign w_tags    = in.sop ? 2'd0 : r_tags;
  assign w_ety     = in.data[2*B-1:0];
  assign w_eth_ctx = in.sop | (r_state == S_ETH);
  assign w_eth_hit = in.valid & w_eth_ctx &
                     ({1'b0, w_widx} == (9'(ETYPE_WORD) + {7'd0, w_tags}));
  assign w_tag_ok  = ((w_ety == ETH_VLAN) | (w_ety == ETH_QINQ) | (w_ety == ETH_VLAN2)) &
                     (32'(w_tags) < MAX_VLAN_TAGS);
  assign w_v4      = (w_ety == ETH_IPV4);
  assign w_v6      = IPV6_EN & (w_ety == ETH_IPV6);
  assign w_l3_ok   = ~w_tag_ok & (w_v4 | w_v6);
  assign w_to_done = w_eth_hit & ~w_tag_ok & ~w_l3_ok;
  assign w_l3_acc  = in.valid & ~in.sop & (r_state == S_L3);
  assign w_clr     = in.valid & in.sop;
  assign w_all_done = &w_done;
  assign w_outst   = (w_eth_ctx & ~w_to_done) | (w_l3_acc & ~w_all_done);

  generate
    for (genvar gi = 0; gi < N_FIELDS; gi++) begin : g_slot
      localparam field_desc_t c_desc = {FIELD_WORD[(N_FIELDS-1-gi)*8 +: 8],
                                        FIELD_OFFSET[(N_FIELDS-1-gi)*8 +: 8],
                                        FIELD_SIZE[(N_FIELDS-1-gi)*8 +: 8]};
      field_slot #(
        .MAX_FIELD_SIZE (MAX_FIELD_SIZE),
        .DESC           (c_desc)
      ) u_slot (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .i_st     (in),
        .i_en     (w_l3_acc),
        .i_clr    (w_clr),
        .i_l3_idx (r_l3idx),
        .o_field  (field[gi]),
        .o_valid  (field_valid[gi]),
        .o_done   (w_done[gi])
      );
    end
  endgenerate

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_wcnt      <= 8'd0;
      r_tags      <= 2'd0;
      r_l3idx     <= 8'd0;
      r_l3_start  <= 1'b0;
      r_is_ipv6   <= 1'b0;
      r_all_valid <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_l3_start  <= 1'b0;
      r_all_valid <= 1'b0;
      r_abort     <= 1'b0;
      if (in.valid) begin
        r_wcnt <= w_widx;
        if (in.sop) begin
          r_state   <= S_ETH;
          r_tags    <= 2'd0;
          r_is_ipv6 <= 1'b0;
          r_abort   <= (r_state == S_L3);
        end
        if (w_eth_hit) begin
          if (w_tag_ok) begin
            r_tags  <= w_tags + 2'd1;
            r_state <= S_ETH;
          end else if (w_l3_ok) begin
            r_state    <= S_L3;
            r_l3idx    <= 8'd0;
            r_is_ipv6  <= w_v6;
            r_l3_start <= ~in.eop;
          end else begin
            r_state <= S_DONE;
          end
        end else if (w_l3_acc) begin
          r_l3idx <= sat_inc(r_l3idx);
          if (w_all_done) begin
            r_all_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        // Packet ended with fields still missing.
        if (in.eop && w_outst) begin
          r_abort <= 1'b1;
          r_state <= S_IDLE;
        end
      end
    end
  end

  assign l3_start  = r_l3_start;
  assign is_ipv6   = r_is_ipv6;
  assign all_valid = r_all_valid;
  assign abort     = r_abort;

endmodule

`default_nettype wire

// File: tb/tb_multi_field_extract.sv
// -----------------------------------------------------------------------------
// tb_multi_field_extract : directed bench, default and straddle/IPv6 instances
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_multi_field_extract;
  import multi_field_extract_pkg::*;

  logic            clk;
  logic            reset_n;
  avln_st_t        st;

  logic            la, ia, ava, aba;
  logic [1:0]      fva;
  logic [1:0][31:0] fa;
  logic            lb, ib, avb, abb;
  logic [1:0]      fvb;
  logic [1:0][31:0] fb;

  int n_cmp = 0;
  int n_err = 0;

  multi_field_extract dut_a (
    .sys_clk     (clk),
    .reset_n     (reset_n),
    .in          (st),
    .l3_start    (la),
    .is_ipv6     (ia),
    .field       (fa),
    .field_valid (fva),
    .all_valid   (ava),
    .abort       (aba)
  );

  // Field 1 straddles L3 words 1/2; one tag allowed; IPv6 accepted.
  multi_field_extract #(
    .N_FIELDS       (2),
    .MAX_FIELD_SIZE (32),
    .FIELD_WORD     ({8'd1, 8'd1}),
    .FIELD_OFFSET   ({8'd0, 8'd24}),
    .FIELD_SIZE     ({8'd16, 8'd16}),
    .ETYPE_WORD     (3),
    .MAX_VLAN_TAGS  (1),
    .IPV6_EN        (1'b1)
  ) dut_b (
    .sys_clk     (clk),
    .reset_n     (reset_n),
    .in          (st),
    .l3_start    (lb),
    .is_ipv6     (ib),
    .field       (fb),
    .field_valid (fvb),
    .all_valid   (avb),
    .abort       (abb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic e, input logic [31:0] d);
    st.valid = v;
    st.sop   = s;
    st.eop   = e;
    st.data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic hdr(input logic [15:0] ety);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, {16'h0, ety});
  endtask

  initial begin
    reset_n = 1'b0;
    st      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl_a", {la, ia, fva, ava, aba}, 64'h0);
    chk("rst_ctl_b", {lb, ib, fvb, avb, abb}, 64'h0);
    chk("rst_field_a", fa, 64'h0);
    reset_n = 1'b1;

    // Untagged IPv4
    hdr(16'h0800);
    chk("s1_l3start", {la, lb, ia}, 64'h6);
    step(1'b1, 1'b0, 1'b0, 32'h4500_0000);
    chk("s1_w0_quiet", {la, fva, fvb}, 64'h0);
    step(1'b1, 1'b0, 1'b0, 32'h1234_ABCD);
    chk("s1_fv0", {fva, ava, fvb, avb}, 64'b01_0_01_0);
    chk("s1_f0", {fa[0], fb[0]}, 64'h1234_0000_1234);
    step(1'b1, 1'b0, 1'b0, 32'h9956_5677);
    chk("s1_fv1", {fva, ava, fvb, avb}, 64'b10_1_10_1);
    chk("s1_f1a", fa[1], 64'h56);
    chk("s1_f1b_straddle", fb[1], 64'hCD99);
    step(1'b1, 1'b0, 1'b1, 32'h0);
    chk("s1_eop_done", {fva, ava, aba, abb}, 64'h0);

    // Double tag: dut_a parses, dut_b exceeds its one-tag limit
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0000_88A8);
    step(1'b1, 1'b0, 1'b0, 32'h0000_8100);
    chk("s2_no_early_start", {la, lb}, 64'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0000_0800);
    chk("s2_l3start", {la, lb}, 64'b10);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h1234_0000);
    chk("s2_f0", {fva, fvb, fa[0]}, {28'h0, 2'b01, 2'b00, 32'h1234});
    step(1'b1, 1'b0, 1'b1, 32'h0000_5600);
    chk("s2_eop_complete", {fva, ava, aba, fvb, avb, abb}, 64'b10_1_0_00_0_0);
    chk("s2_f1", fa[1], 64'h56);

    // Straddle across idle cycles
    hdr(16'h0800);
    chk("s3_l3start", {la, lb}, 64'b11);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h5555_11AB);
    chk("s3_f0", {fvb, fb[0]}, {30'h0, 2'b01, 32'h5555});
    step(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    chk("s3_idle1", {fva, fvb, ava, avb}, 64'h0);
    step(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    chk("s3_idle2", {fva, fvb, ava, avb}, 64'h0);
    step(1'b1, 1'b0, 1'b0, 32'hCD00_0000);
    chk("s3_fv1", {fva, ava, fvb, avb}, 64'b10_1_10_1);
    chk("s3_f1b", fb[1], 64'hABCD);
    chk("s3_f1a", fa[1], 64'h0);
    step(1'b1, 1'b0, 1'b1, 32'h0);

    // Early eop on L3 word 1
    hdr(16'h0800);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h7777_0000);
    chk("s4_fv0", {fva, fvb}, 64'b01_01);
    chk("s4_abort", {ava, aba, avb, abb}, 64'b0101);
    chk("s4_f0", {fa[0], fb[0]}, 64'h7777_0000_7777);
    step(1'b1, 1'b0, 1'b0, 32'h0000_0800);
    chk("s4_idle_ignores", {la, lb, aba, abb}, 64'h0);

    // Ethertype 0x86DD: rejected by dut_a, accepted by dut_b
    hdr(16'h86DD);
    chk("s5_v6", {la, ia, lb, ib}, 64'b0011);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'hBEEF_0012);
    chk("s5_f0", {fva, fvb, fb[0]}, {28'h0, 2'b00, 2'b01, 32'hBEEF});
    step(1'b1, 1'b0, 1'b1, 32'h3400_0000);
    chk("s5_f1", {fvb, avb, abb, ib, fb[1]}, {27'h0, 2'b10, 1'b1, 1'b0, 1'b1, 32'h1234});
    chk("s5_a_quiet", {fva, ava, aba, fa[1]}, 64'h0);

    // Back-to-back sop clears is_ipv6; missing eop in L3 aborts
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("s6_ipv6_clr", ib, 64'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0000_0800);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("s6_sop_abort", {aba, abb}, 64'b11);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0000_0800);
    chk("s6_restart_l3", {la, lb, aba}, 64'b110);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'hA5A5_0000);
    chk("s6_f0", fa[0], 64'hA5A5);

    // Reset mid-L3
    reset_n = 1'b0;
    #1;
    chk("s6_rst_fa", fa, 64'h0);
    chk("s6_rst_fb", fb, 64'h0);
    chk("s6_rst_ctl", {la, ia, fva, ava, aba, lb, ib, fvb, avb, abb}, 64'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    hdr(16'h0800);
    chk("s6_post_l3start", la, 64'h1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h4321_0000);
    chk("s6_post_f0", {fva, fa[0]}, {30'h0, 2'b01, 32'h4321});
    step(1'b1, 1'b0, 1'b1, 32'h0000_6500);
    chk("s6_post_f1", {fva, ava, aba, fa[1]}, {29'h0, 2'b10, 1'b1, 1'b0, 32'h65});
    chk("s6_post_b", {avb, abb}, 64'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_field_extract.md
Name: multi_field_extract

Overview:
- Parametrised successor to the single-field IPv4 start finder and field getter.
- Parses the Ethernet/VLAN header of every packet on the Avalon-ST stream: up to MAX_VLAN_TAGS stacked tags, with IPv4 and optionally IPv6 as L3.
- Captures N_FIELDS independently placed L3-header fields in one pass; a field may straddle a word boundary.
- Sits in the internal pipeline in parallel with the packet FIFO; feeds the windowing and decision logic.

Parameters:
- N_FIELDS, 2, number of extracted fields (1..8).
- MAX_FIELD_SIZE, 32, output width per field in bits; must be <= W.
- FIELD_WORD, {8'd1,8'd2}, packed array, N_FIELDS x 8 bits; word index of each field's MSB, relative to the first L3 word (index 0).
- FIELD_OFFSET, {8'd0,8'd16}, packed array, N_FIELDS x 8 bits; bit offset from the word MSB.
- FIELD_SIZE, {8'd16,8'd8}, packed array, N_FIELDS x 8 bits; field width; 1..MAX_FIELD_SIZE.
- ETYPE_WORD, 3, word index holding the outer ethertype in data[2*B-1:0].
- MAX_VLAN_TAGS, 2, maximum number of stacked tags skipped (0..3).
- IPV6_EN, 0, accept ethertype 0x86DD as L3 start.

Ports:
- sys_clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in  in  avln_st  input stream (data, valid, sop, eop)
- l3_start  out  1  one-cycle pulse; the next valid word is L3 word 0
- is_ipv6  out  1  L3 type of the current packet; held until next sop
- field  out  [N_FIELDS][MAX_FIELD_SIZE]  captured fields, right-aligned, zero-extended; held
- field_valid  out  N_FIELDS  one-cycle pulse per field on the capture cycle
- all_valid  out  1  one-cycle pulse on the cycle the last outstanding field is captured
- abort  out  1  one-cycle pulse: eop, or a new sop, while fields are still outstanding

Behaviour:
- Reset: all outputs 0, FSM in IDLE, word counter 0, tag count 0.
- The word counter advances only on in.valid. On in.sop & in.valid it restarts at 0 and the sop word counts as word 0. It saturates at 255.
- FSM states: IDLE, ETH, L3, DONE.
- IDLE: waits for sop & valid, then goes to ETH and clears the tag count.
  - If ETYPE_WORD==0, the ethertype check happens on the sop word itself.
- ETH: on the valid word with index ETYPE_WORD + tag count, decode data[2*B-1:0]:
  - 0x8100, 0x88A8 or 0x9100 with tag count < MAX_VLAN_TAGS: increment tag count, stay in ETH.
  - 0x0800: go to L3, pulse l3_start next cycle, is_ipv6=0.
  - 0x86DD with IPV6_EN: same as 0x0800, but is_ipv6=1.
  - Anything else, including a tag beyond the limit: go to DONE, with no abort.
- L3: the L3 word index resets to 0 on the first valid word after the ethertype word.
  - For field i, with end bit E = FIELD_OFFSET + FIELD_SIZE:
    - If E <= W: capture data[W-1-OFF : W-OFF-SIZE] on L3 word FIELD_WORD.
    - If E > W: latch the upper W-OFF bits on word FIELD_WORD and the remaining bits from the MSBs of word FIELD_WORD+1. The capture cycle is the second word.
  - field and field_valid are registered: 1-cycle latency after the accepted word.
  - Multiple fields may capture on the same cycle.
  - When every field has captured: all_valid pulses with the last field_valid, then go to DONE.
- DONE: ignores words until the next sop & valid, then goes to ETH.
- eop in ETH or L3 with fields outstanding:
  - Pulse abort on the cycle after the eop, then go to IDLE.
  - Fields captured on the eop word itself still pulse field_valid.
  - all_valid pulses only if that word completes all fields; in that case there is no abort.
- sop arriving in ETH or L3 (missing eop): pulse abort if in L3 with fields outstanding, then restart parsing on that word.
- field keeps its last value across packets. is_ipv6 clears on sop.
- in.valid low: nothing advances and no decode happens.
- Reset asserted mid-packet: everything returns to reset values immediately; the stream is resynced at the next sop.

Decomposition:
- Shared package gets:
  - ETH_IPV4=16'h0800, ETH_IPV6=16'h86DD, ETH_VLAN=16'h8100, ETH_QINQ=16'h88A8, ETH_VLAN2=16'h9100
  - the typedef of the FSM state enum
  - a field_desc_t struct {word, offset, size}
- One sub-module, field_slot: per-field capture with the straddle latch. Instantiate it N_FIELDS times in a generate loop. It takes the L3 word index, in, and the enable; it returns field, valid and done.

Test Plan:
1. Untagged IPv4 with defaults:
   - Stimulus: word 3 low = 0x0800, L3 word 1 = 0x1234_xxxx, L3 word 2 = 0xxx56_xxxx.
   - Response: l3_start 1 cycle after word 3; field[0]=0x1234 on word 1 +1; field[1]=0x56; all_valid with field 1.
2. Double tag:
   - Stimulus: 0x88A8 at word 3, 0x8100 at word 4, 0x0800 at word 5.
   - Response: L3 word 0 = word 6; same field values as scenario 1.
   - With MAX_VLAN_TAGS=1 the same packet goes to DONE; no outputs, no abort.
3. Straddle:
   - Stimulus: FIELD_OFFSET=24, SIZE=16 on word 1; word 1 LSB byte 0xAB, word 2 MSB byte 0xCD, with idle (valid=0) cycles between them.
   - Response: field=0xABCD one cycle after word 2.
4. Early eop:
   - Stimulus: eop on L3 word 1.
   - Response: field_valid[0] pulses; abort pulses; no all_valid; FSM in IDLE.
5. IPV6_EN=0 with ethertype 0x86DD -> no l3_start. IPV6_EN=1 -> l3_start, is_ipv6=1.
6. Back-to-back packets, and reset_n low mid-L3:
   - Back-to-back: sop immediately after eop parses correctly.
   - Reset mid-L3: all outputs 0 that cycle; the next packet extracts correctly.
